// File: rtl/cam_capture_ctrl_if.sv
// Camera parallel bus plus frame buffer write port of the capture engine.
// master = capture engine side, slave = camera / frame buffer side.
interface cam_capture_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 12
);
  logic              pclk;
  logic              vsync;
  logic              href;
  logic [7:0]        pix_data_in;
  logic              pix_wr;
  logic [PIX_W-1:0]  pix_data_out;
  logic [ADDR_W-1:0] pix_addr;

  modport master (
    input  pclk, vsync, href, pix_data_in,
    output pix_wr, pix_data_out, pix_addr
  );

  modport slave (
    output pclk, vsync, href, pix_data_in,
    input  pix_wr, pix_data_out, pix_addr
  );
endinterface

// File: rtl/cam_capture_ctrl.sv
// OV7670 capture engine: oversamples the camera bus on clk, packs byte pairs
// into 12-bit pixels and streams them to the frame buffer write port.
module cam_capture_ctrl #(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_done,
  input  logic       cont,
  input  logic       arm,
  input  logic [1:0] mode,
  input  logic       decim,
  cam_capture_ctrl_if.master bus,
  output logic       frame_done,
  output logic       busy,
  output logic       line_err,
  output logic [7:0] frame_cnt
);

  localparam int XW = $clog2(H_ACT + 2);
  localparam int YW = $clog2(V_ACT + 1);
  localparam logic [XW-1:0]   X_END    = XW'(H_ACT);
  localparam logic [XW-1:0]   X_SAT    = XW'(H_ACT + 1);
  localparam logic [YW-1:0]   Y_END    = YW'(V_ACT);
  localparam logic [ADDR_W:0] LIM_FULL = (ADDR_W+1)'(H_ACT * V_ACT);
  localparam logic [ADDR_W:0] LIM_DEC  = (ADDR_W+1)'((H_ACT / 2) * (V_ACT / 2));

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_ACTIVE, S_DONE} state_t;

  state_t            r_state;
  logic [2:0]        r_pclk_s, r_vs_s, r_href_s;
  logic [7:0]        r_d0, r_d1;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [1:0]        r_mode;
  logic              r_decim;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W:0]   r_wcnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_pix_wr;
  logic [PIX_W-1:0]  r_pix;
  logic              r_frame_done, r_busy, r_line_err;
  logic [7:0]        r_frame_cnt;

  logic        w_byte, w_href, w_href_fall, w_vs_fall, w_vs_rise;
  logic        w_pix_evt, w_qual;
  logic [11:0] w_pix;

  // Index 1 is the synchronised level, index 2 its one-clk-old copy for edges.
  assign w_byte      = r_pclk_s[1] & ~r_pclk_s[2];
  assign w_href      = r_href_s[1];
  assign w_href_fall = ~r_href_s[1] & r_href_s[2];
  assign w_vs_fall   = ~r_vs_s[1] & r_vs_s[2];
  assign w_vs_rise   = r_vs_s[1] & ~r_vs_s[2];
  assign w_pix_evt   = w_byte & w_href & r_phase;

  assign w_qual = (r_x < X_END) && (r_y < Y_END) &&
                  (!r_decim || (!r_x[0] && !r_y[0])) &&
                  (r_wcnt < (r_decim ? LIM_DEC : LIM_FULL));

  // r_hi holds the first byte, r_d1 is the second byte being sampled now.
  always_comb begin
    w_pix = {r_hi[7:4], r_hi[2:0], r_d1[7], r_d1[4:1]};
    case (r_mode)
      2'b01:   w_pix = {r_hi[3:0], r_d1};
      2'b10:   w_pix = {3{r_hi[7:4]}};
      default: w_pix = {r_hi[7:4], r_hi[2:0], r_d1[7], r_d1[4:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pclk_s     <= '0;
      r_vs_s       <= '0;
      r_href_s     <= '0;
      r_d0         <= '0;
      r_d1         <= '0;
      r_phase      <= 1'b0;
      r_hi         <= '0;
      r_mode       <= '0;
      r_decim      <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_wcnt       <= '0;
      r_addr       <= '0;
      r_pix_wr     <= 1'b0;
      r_pix        <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_line_err   <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_pclk_s     <= {r_pclk_s[1:0], bus.pclk};
      r_vs_s       <= {r_vs_s[1:0], bus.vsync};
      r_href_s     <= {r_href_s[1:0], bus.href};
      r_d0         <= bus.pix_data_in;
      r_d1         <= r_d0;
      r_pix_wr     <= 1'b0;
      r_frame_done <= 1'b0;

      if (!w_href) r_phase <= 1'b0;
      else if (w_byte) begin
        r_phase <= ~r_phase;
        if (!r_phase) r_hi <= r_d1;
      end

      // Address saturates rather than wrapping past the top of the buffer.
      if (r_pix_wr && (r_addr != '1)) r_addr <= r_addr + 1'b1;

      if (!cfg_done) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (cont || arm) begin
            r_state <= S_WAIT_VS;
            r_busy  <= 1'b1;
          end
          S_WAIT_VS: if (w_vs_fall) begin
            r_state    <= S_ACTIVE;
            r_mode     <= mode;
            r_decim    <= decim;
            r_addr     <= '0;
            r_wcnt     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_line_err <= 1'b0;
          end
          S_ACTIVE: begin
            if (w_vs_rise) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
              r_frame_cnt  <= r_frame_cnt + 1'b1;
            end else begin
              if (w_pix_evt) begin
                if (w_qual) begin
                  r_pix_wr <= 1'b1;
                  r_pix    <= PIX_W'(w_pix);
                  r_wcnt   <= r_wcnt + 1'b1;
                end
                if (r_x != X_SAT) r_x <= r_x + 1'b1;
              end
              // An odd byte count leaves the phase at 1 when href drops.
              if (w_href_fall) begin
                if ((r_y < Y_END) && ((r_x != X_END) || r_phase)) r_line_err <= 1'b1;
                r_x <= '0;
                if (r_y != Y_END) r_y <= r_y + 1'b1;
              end
            end
          end
          S_DONE: begin
            if (cont) r_state <= S_WAIT_VS;
            else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.pix_wr       = r_pix_wr;
  assign bus.pix_data_out = r_pix;
  assign bus.pix_addr     = r_addr;
  assign frame_done       = r_frame_done;
  assign busy             = r_busy;
  assign line_err         = r_line_err;
  assign frame_cnt        = r_frame_cnt;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Drives synthetic OV7670 frames and checks every frame buffer write against
// a queue of expected (address, pixel) pairs built from the capture rules.
module tb_cam_capture_ctrl;
  localparam int H      = 8;
  localparam int V      = 4;
  localparam int ADDR_W = 5;

  logic       clk, rst, cfg_done, cont, arm, decim;
  logic [1:0] mode;
  logic       frame_done, busy, line_err;
  logic [7:0] frame_cnt;

  cam_capture_ctrl_if #(.ADDR_W(ADDR_W), .PIX_W(12)) bus ();

  cam_capture_ctrl #(.H_ACT(H), .V_ACT(V), .ADDR_W(ADDR_W), .PIX_W(12)) dut (
    .clk(clk), .rst(rst), .cfg_done(cfg_done), .cont(cont), .arm(arm),
    .mode(mode), .decim(decim), .bus(bus),
    .frame_done(frame_done), .busy(busy), .line_err(line_err), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int addr; int data;} exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_err = 0, n_wr = 0;
  int dut_frames = 0, exp_frames = 0, exp_cnt = 0;
  int m_mode = 0, m_decim = 0, m_wcnt = 0, m_err = 0;
  int lens[8];
  logic [7:0] g_hi, g_lo;
  bit g_rand_hi = 0, g_rand_lo = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Pixel value from the byte pair, composed field by field.
  function automatic int pack(input int md, input int hi, input int lo);
    int r, g, b;
    case (md)
      1: return ((hi % 16) * 256) + lo;
      2: return (hi / 16) * 'h111;
      default: begin
        r = hi / 16;
        g = ((hi % 8) * 2) + (lo / 128);
        b = (lo / 2) % 16;
        return r * 256 + g * 16 + b;
      end
    endcase
  endfunction

  function automatic void model_pix(input int y, input int x, input int hi, input int lo);
    int lim;
    lim = m_decim ? (H / 2) * (V / 2) : H * V;
    if (x < H && y < V && (m_decim == 0 || (x % 2 == 0 && y % 2 == 0)) && m_wcnt < lim) begin
      exp_q.push_back('{m_wcnt, pack(m_mode, hi, lo)});
      m_wcnt++;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (bus.pix_wr) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL wr_unexpected: write addr %0d data 0x%0h, none expected",
                   bus.pix_addr, bus.pix_data_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", int'(bus.pix_addr), e.addr);
          check("wr_data", int'(bus.pix_data_out), e.data);
        end
      end
      if (frame_done) dut_frames++;
    end
  end

  task automatic pclk_cycle(input logic h, input logic [7:0] d);
    @(negedge clk);
    bus.pclk = 1'b0;
    bus.href = h;
    bus.pix_data_in = d;
    @(negedge clk);
    @(negedge clk);
    bus.pclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_begin(input bit cap);
    bus.vsync = 1'b1;
    repeat (4) pclk_cycle(1'b0, 8'h00);
    bus.vsync = 1'b0;
    if (cap) begin
      m_mode  = (int'(mode) == 3) ? 0 : int'(mode);
      m_decim = int'(decim);
      m_wcnt  = 0;
      m_err   = 0;
    end
    repeat (2) pclk_cycle(1'b0, 8'h00);
  endtask

  task automatic send_line(input int y, input int len, input bit cap);
    logic [7:0] hi, lo;
    for (int p = 0; p < len; p++) begin
      hi = g_rand_hi ? 8'($urandom) : g_hi;
      lo = g_rand_lo ? 8'($urandom) : g_lo;
      if (cap) model_pix(y, p, int'(hi), int'(lo));
      pclk_cycle(1'b1, hi);
      pclk_cycle(1'b1, lo);
    end
    if (cap && y < V && len != H) m_err = 1;
    repeat (3) pclk_cycle(1'b0, 8'h00);
  endtask

  task automatic frame_end(input bit cap);
    bus.vsync = 1'b1;
    repeat (2) pclk_cycle(1'b0, 8'h00);
    if (cap) begin
      exp_frames++;
      exp_cnt++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input bit cap, input int nl);
    frame_begin(cap);
    for (int l = 0; l < nl; l++) send_line(l, lens[l], cap);
    frame_end(cap);
  endtask

  task automatic do_arm();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_frames"}, dut_frames, exp_frames);
    check({tag, "_cnt"}, int'(frame_cnt), exp_cnt % 256);
    check({tag, "_lerr"}, int'(line_err), m_err);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr"}, int'(bus.pix_wr), 0);
    check({tag, "_data"}, int'(bus.pix_data_out), 0);
    check({tag, "_addr"}, int'(bus.pix_addr), 0);
    check({tag, "_fdone"}, int'(frame_done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_lerr"}, int'(line_err), 0);
    check({tag, "_cnt"}, int'(frame_cnt), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, nl;
    rst = 1'b0; cfg_done = 1'b0; cont = 1'b0; arm = 1'b0; mode = 2'd0; decim = 1'b0;
    bus.pclk = 1'b0; bus.vsync = 1'b1; bus.href = 1'b0; bus.pix_data_in = 8'h00;
    for (int i = 0; i < 8; i++) lens[i] = H;
    g_hi = 8'hF8; g_lo = 8'h1F;
    repeat (3) @(negedge clk);
    check_zero("rst");

    check("pack_565", pack(0, 'hF8, 'h1F), 'hF0F);
    check("pack_444", pack(1, 'h0A, 'hBC), 'hABC);
    check("pack_y", pack(2, 'hA5, 'h3C), 'hAAA);
    check("pack_11", pack(3, 'hF8, 'h1F), 'hF0F);

    rst = 1'b1;
    @(negedge clk);
    cfg_done = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Single-shot RGB565 frame, then a frame that must be ignored.
    do_arm();
    check("ss_busy", int'(busy), 1);
    w0 = n_wr;
    send_frame(1, 4);
    check_frame("ss");
    check("ss_writes", n_wr - w0, 32);
    check("ss_cnt_lit", int'(frame_cnt), 1);
    check("ss_data_lit", int'(bus.pix_data_out), 'hF0F);
    check("ss_busy_end", int'(busy), 0);
    w0 = n_wr;
    send_frame(0, 4);
    check_frame("ss_ign");
    check("ss_ign_writes", n_wr - w0, 0);

    // Continuous luma capture over three frames.
    mode = 2'd2; g_hi = 8'hA5; g_rand_lo = 1;
    cont = 1'b1;
    w0 = n_wr;
    for (int f = 0; f < 3; f++) begin
      frame_begin(1);
      for (int l = 0; l < V; l++) send_line(l, H, 1);
      if (f == 2) cont = 1'b0;
      frame_end(1);
    end
    check_frame("cont");
    check("cont_writes", n_wr - w0, 96);
    check("cont_cnt_lit", int'(frame_cnt), 4);
    check("cont_data_lit", int'(bus.pix_data_out), 'hAAA);

    // Decimated RGB444.
    mode = 2'd1; decim = 1'b1; g_hi = 8'h0A; g_lo = 8'hBC; g_rand_lo = 0;
    do_arm();
    w0 = n_wr;
    send_frame(1, 4);
    check_frame("dec");
    check("dec_writes", n_wr - w0, 8);
    check("dec_data_lit", int'(bus.pix_data_out), 'hABC);

    // Short line raises a sticky error that clears at the next frame start.
    mode = 2'd0; decim = 1'b0; g_hi = 8'hF8; g_lo = 8'h1F;
    lens[1] = 7;
    do_arm();
    w0 = n_wr;
    send_frame(1, 4);
    check_frame("lerr");
    check("lerr_lit", int'(line_err), 1);
    check("lerr_writes", n_wr - w0, 31);
    lens[1] = H;
    do_arm();
    check("lerr_sticky", int'(line_err), 1);
    frame_begin(1);
    check("lerr_clr", int'(line_err), 0);
    for (int l = 0; l < V; l++) send_line(l, H, 1);
    frame_end(1);
    check_frame("lerr2");

    // Randomised frames: format, decimation, bytes, line count and lengths.
    g_rand_hi = 1; g_rand_lo = 1;
    for (int f = 0; f < 6; f++) begin
      mode  = 2'($urandom_range(0, 3));
      decim = 1'($urandom_range(0, 1));
      nl    = $urandom_range(3, 6);
      for (int l = 0; l < 8; l++) begin
        case ($urandom_range(0, 5))
          0:       lens[l] = H - 1;
          1:       lens[l] = H + 1;
          default: lens[l] = H;
        endcase
      end
      do_arm();
      frame_begin(1);
      mode  = 2'($urandom_range(0, 3));
      decim = 1'($urandom_range(0, 1));
      for (int l = 0; l < nl; l++) send_line(l, lens[l], 1);
      frame_end(1);
      check_frame("rnd");
    end
    for (int i = 0; i < 8; i++) lens[i] = H;
    g_rand_hi = 0; g_rand_lo = 0;
    mode = 2'd0; decim = 1'b0;

    // cfg_done dropped mid-frame.
    do_arm();
    frame_begin(1);
    send_line(0, H, 1);
    @(negedge clk);
    cfg_done = 1'b0;
    @(negedge clk);
    check("cfg_busy", int'(busy), 0);
    w0 = n_wr;
    for (int l = 1; l < V; l++) send_line(l, H, 0);
    frame_end(0);
    check_frame("cfg");
    check("cfg_writes", n_wr - w0, 0);
    cfg_done = 1'b1;

    // Asynchronous reset mid-frame.
    do_arm();
    frame_begin(1);
    send_line(0, H, 1);
    check("prerst_pending", exp_q.size(), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero("mrst");
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0; exp_frames = 0; dut_frames = 0; m_err = 0;
    w0 = n_wr;
    for (int l = 1; l < V; l++) send_line(l, H, 0);
    frame_end(0);
    check_frame("mrst_after");
    check("mrst_writes", n_wr - w0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
